// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO (DATA at BASE, STATUS at BASE+4).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE         = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STATUS_ADR = BASE + 32'd4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
  localparam logic   PAR_EN     = 1'b1;
`else
  localparam state_t AFTER_DATA = S_STOP;
  localparam logic   PAR_EN     = 1'b0;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    even_parity = ^b;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          par_r, par_s;
  logic          tx_r, tx_s;
  logic [AW:0]   wr_ptr_r, rd_ptr_r, count_s;
  logic [7:0]    mem_r [DEPTH];
  logic          ovf_r;
  logic          data_hit_s, status_hit_s, full_s, empty_s, tick_s;
  logic          push_s, drop_s, ovf_clr_s, pop_s, load_s;
  logic [7:0]    pop_data_s;
  logic [31:0]   status_s;

  assign hit          = (dataadr[31:3] == BASE[31:3]);
  assign data_hit_s   = (dataadr[31:2] == BASE[31:2]);
  assign status_hit_s = (dataadr[31:2] == STATUS_ADR[31:2]);
  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign full_s       = (count_s == (AW+1)'(DEPTH));
  assign empty_s      = (count_s == {(AW+1){1'b0}});
  assign tick_s       = (cnt_r == {CW{1'b0}});
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign push_s       = memwrite & data_hit_s & ~full_s;
  assign drop_s       = memwrite & data_hit_s & full_s;
  assign ovf_clr_s    = memwrite & status_hit_s & writedata[3];
  assign pop_data_s   = mem_r[rd_ptr_r[AW-1:0]];
  assign tx           = tx_r;
  assign busy         = (state_r != S_IDLE) | ~empty_s;
  assign readdata     = status_hit_s ? status_s : 32'd0;

  // Frame sequencing: next state, shift/parity capture, FIFO pop and next tx level.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    par_s   = par_r;
    pop_s   = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          load_s  = 1'b1;
          shift_s = pop_data_s;
          par_s   = even_parity(pop_data_s);
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          load_s  = 1'b1;
          idx_s   = 3'd0;
          state_s = S_DATA;
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          load_s  = 1'b1;
          shift_s = {1'b0, shift_r[7:1]};
          idx_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) state_s = AFTER_DATA;
          else               state_s = S_DATA;
        end else begin
          state_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          load_s  = 1'b1;
          state_s = S_STOP;
        end else begin
          state_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (tick_s) begin
          load_s = 1'b1;
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = pop_data_s;
            par_s   = even_parity(pop_data_s);
            state_s = S_START;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      default: state_s = S_IDLE;
    endcase
    case (state_s)
      S_START:  tx_s = 1'b0;
      S_DATA:   tx_s = shift_s[0];
      S_PARITY: tx_s = par_s;
      default:  tx_s = 1'b1;
    endcase
  end

  // FSM, bit timer and registered tx line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      if (load_s)       cnt_r <= BIT_LAST;
      else if (!tick_s) cnt_r <= cnt_r - CW'(1);
      else              cnt_r <= cnt_r;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= writedata[7:0];
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      if (drop_s)         ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_s           = 32'd0;
    status_s[0]        = (state_r != S_IDLE);
    status_s[1]        = full_s;
    status_s[2]        = empty_s;
    status_s[3]        = ovf_r;
    status_s[4]        = PAR_EN;
    status_s[8 +: AW+1] = count_s;
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx at CLKS_PER_BIT=4, DEPTH=8.
// A background receiver decodes frames from tx into queues for the scenario tasks.
module tb_mmio_uart_tx;
  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PARF  = 32'h0000_0010;
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PARF  = 32'h0000_0000;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic        hit, tx, busy;
  logic [31:0] readdata;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mmio_uart_tx #(.BASE(BASE), .CLKS_PER_BIT(CPB), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .hit(hit), .readdata(readdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Background receiver: samples mid-bit on the falling edge.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_start = 0;
  logic [7:0] rx_sh = 8'h0;
  logic       rx_par = 1'b0;
  int         rx_start_q[$];
  logic [7:0] rx_data_q[$];
  logic       rx_par_q[$];
  logic       rx_stop_q[$];

  always @(negedge clk) begin
    if (reset) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy  <= 1'b1;
        rx_cnt   <= 1;
        rx_start <= cyc;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] <= tx;
        if (NBITS == 11 && rx_cnt / CPB == 9) rx_par <= tx;
        if (rx_cnt / CPB == NBITS - 1) begin
          rx_start_q.push_back(rx_start);
          rx_data_q.push_back(rx_sh);
          rx_par_q.push_back(rx_par);
          rx_stop_q.push_back(tx);
          rx_busy <= 1'b0;
        end
      end
    end
  end

  task automatic clear_rx();
    rx_start_q.delete();
    rx_data_q.delete();
    rx_par_q.delete();
    rx_stop_q.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(posedge clk); #1;
    memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    dataadr = BASE + 32'd4;
    #1 v = readdata;
    dataadr = 32'h0;
  endtask

  task automatic wait_idle(input int max, output int c, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b0) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    c = cyc;
  endtask

  task automatic test_reset();
    logic [31:0] st;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    read_status(st);
    checks++; if (st !== (32'h4 | PARF)) begin errors++; $display("FAIL reset_status: got %h expected %h", st, 32'h4 | PARF); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] st;
    logic [10:0] fr;
    int c;
    bit to;
`ifdef UART_TX_PARITY_EN
    fr = 11'b1_0_10100101_0;
`else
    fr = 11'b11_10100101_0;
`endif
    clear_rx();
    @(posedge clk); #1;
    store(BASE, 32'h0000_00A5);
    read_status(st);
    checks++; if (st !== (32'h100 | PARF)) begin errors++; $display("FAIL single_status: got %h expected %h", st, 32'h100 | PARF); end
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk); #1;
      checks++; if (tx !== fr[(k-1)/CPB]) begin errors++; $display("FAIL single_tx cycle %0d: got %b expected %b", k, tx, fr[(k-1)/CPB]); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    wait_idle(10, c, to);
    checks++; if (rx_data_q.size() !== 1) begin errors++; $display("FAIL single_frames: got %0d expected 1", rx_data_q.size()); end
    else begin
      checks++; if (rx_data_q[0] !== 8'hA5 || rx_stop_q[0] !== 1'b1) begin errors++; $display("FAIL single_rx: got %h/%b expected a5/1", rx_data_q[0], rx_stop_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] st;
    logic [7:0] exp_d [3];
    int c;
    bit to;
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    clear_rx();
    store(BASE, 32'h41);
    store(BASE, 32'h42);
    store(BASE, 32'h43);
    read_status(st);
    checks++; if (st !== (32'h201 | PARF)) begin errors++; $display("FAIL b2b_status: got %h expected %h", st, 32'h201 | PARF); end
    wait_idle(600, c, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got busy=%b expected 0", busy); end
    checks++; if (rx_data_q.size() !== 3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", rx_data_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (rx_data_q[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data %0d: got %h expected %h", i, rx_data_q[i], exp_d[i]); end
      end
      checks++; if (rx_start_q[1] - rx_start_q[0] !== FRAME || rx_start_q[2] - rx_start_q[1] !== FRAME) begin
        errors++; $display("FAIL b2b_gap: got %0d,%0d expected %0d", rx_start_q[1] - rx_start_q[0], rx_start_q[2] - rx_start_q[1], FRAME);
      end
      checks++; if (c - rx_start_q[0] !== 3 * FRAME) begin errors++; $display("FAIL b2b_total: got %0d expected %0d", c - rx_start_q[0], 3 * FRAME); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] st;
    int c;
    bit to;
    clear_rx();
    for (int i = 0; i < 10; i++) store(BASE, 32'h10 + i);
    read_status(st);
    checks++; if (st !== (32'h80B | PARF)) begin errors++; $display("FAIL ovf_status: got %h expected %h", st, 32'h80B | PARF); end
    store(BASE + 32'd4, 32'h8);
    read_status(st);
    checks++; if (st !== (32'h803 | PARF)) begin errors++; $display("FAIL ovf_clear: got %h expected %h", st, 32'h803 | PARF); end
    wait_idle(1500, c, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout: got busy=%b expected 0", busy); end
    checks++; if (rx_data_q.size() !== 9) begin errors++; $display("FAIL ovf_frames: got %0d expected 9", rx_data_q.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        checks++; if (rx_data_q[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL ovf_data %0d: got %h expected %h", i, rx_data_q[i], 8'(8'h10 + i)); end
      end
    end
    read_status(st);
    checks++; if (st !== (32'h4 | PARF)) begin errors++; $display("FAIL ovf_final: got %h expected %h", st, 32'h4 | PARF); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] st;
    int lows;
    clear_rx();
    store(BASE, 32'h5A);
    store(BASE, 32'h3C);
    repeat (14) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    read_status(st);
    checks++; if (st !== (32'h4 | PARF)) begin errors++; $display("FAIL mid_status: got %h expected %h", st, 32'h4 | PARF); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_rx();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", lows); end
    checks++; if (rx_data_q.size() !== 0) begin errors++; $display("FAIL mid_frames: got %0d expected 0", rx_data_q.size()); end
  endtask

  task automatic test_addr_decode();
    logic [31:0] st;
    int act;
    memwrite = 1'b1; writedata = 32'h55; dataadr = BASE + 32'd8;
    #1;
    checks++; if (hit !== 1'b0 || readdata !== 32'h0) begin errors++; $display("FAIL dec_plus8: got hit=%b rd=%h expected 0/0", hit, readdata); end
    @(posedge clk); #1;
    dataadr = BASE - 32'd4;
    #1;
    checks++; if (hit !== 1'b0 || readdata !== 32'h0) begin errors++; $display("FAIL dec_minus4: got hit=%b rd=%h expected 0/0", hit, readdata); end
    @(posedge clk); #1;
    memwrite = 1'b0;
    dataadr = BASE;
    #1;
    checks++; if (hit !== 1'b1 || readdata !== 32'h0) begin errors++; $display("FAIL dec_data: got hit=%b rd=%h expected 1/0", hit, readdata); end
    dataadr = BASE + 32'd4;
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL dec_status_hit: got %b expected 1", hit); end
    dataadr = 32'h0;
    read_status(st);
    checks++; if (st !== (32'h4 | PARF)) begin errors++; $display("FAIL dec_fifo: got %h expected %h", st, 32'h4 | PARF); end
    act = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL dec_quiet: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_parity();
    logic [31:0] st;
    read_status(st);
`ifdef UART_TX_PARITY_EN
    begin
      logic [10:0] fr;
      fr = 11'b1_1_00000111_0;
      checks++; if (st[4] !== 1'b1) begin errors++; $display("FAIL par_flag: got %b expected 1", st[4]); end
      clear_rx();
      store(BASE, 32'h07);
      for (int k = 1; k <= 44; k++) begin
        @(posedge clk); #1;
        checks++; if (tx !== fr[(k-1)/CPB]) begin errors++; $display("FAIL par_tx cycle %0d: got %b expected %b", k, tx, fr[(k-1)/CPB]); end
      end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_busy: got %b expected 0", busy); end
      checks++; if (rx_par_q.size() !== 1) begin errors++; $display("FAIL par_frames: got %0d expected 1", rx_par_q.size()); end
      else begin
        checks++; if (rx_par_q[0] !== 1'b1 || rx_data_q[0] !== 8'h07) begin errors++; $display("FAIL par_rx: got %h/%b expected 07/1", rx_data_q[0], rx_par_q[0]); end
      end
    end
`else
    checks++; if (st[4] !== 1'b0) begin errors++; $display("FAIL par_flag: got %b expected 0", st[4]); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_addr_decode();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the single-cycle core's data port. Sits beside dmem, downstream of the core's memwrite/dataadr/writedata outputs.
- Stores to its DATA word push a byte into a small FIFO. A frame FSM serialises the FIFO bytes onto a TX line (8N1).
- Loads from its STATUS word return FIFO and transmitter state. The top-level readdata mux selects this block's readdata when hit=1.

Parameters:
- BASE, 32'hFFFF_0000: byte address of DATA; STATUS is BASE+4. Must be 8-byte aligned.
- CLKS_PER_BIT, 16: clk cycles per serial bit, ≥2.
- DEPTH, 8: FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- memwrite  in  1  core store strobe
- dataadr  in  32  core data address
- writedata  in  32  core store data
- hit  out  1  combinational; 1 when dataadr[31:3]==BASE[31:3]
- readdata  out  32  combinational load data
- tx  out  1  serial output, idle high
- busy  out  1  1 when FSM not IDLE or FIFO non-empty

Behaviour:
- Address decode
  - DATA hit: dataadr==BASE (bits [1:0] ignored).
  - STATUS hit: dataadr==BASE+4.
  - Any other address: no state change; readdata=0.
- Store to DATA with memwrite=1
  - Pushes writedata[7:0] at the clock edge if FIFO not full.
  - If full, the byte is dropped and sticky ovf is set.
  - Full is sampled before any same-cycle pop, so a push when full is dropped even if a pop occurs that cycle.
- Store to STATUS: writedata[3]=1 clears ovf; all other bits are ignored.
- STATUS readdata
  - [0] fsm_active
  - [1] full
  - [2] empty
  - [3] ovf
  - [7:4] reserved, 0
  - [8+:$clog2(DEPTH)+1] count
  - remaining bits 0
- DATA readdata: 0.
- FIFO
  - Circular buffer with wr/rd pointers of $clog2(DEPTH)+1 bits; pointers wrap naturally.
  - count = wr-rd.
  - full when count==DEPTH; empty when count==0.
- Bit timer
  - Counter loads CLKS_PER_BIT-1 on each state entry and decrements each cycle.
  - tick = (counter==0). A state advances only on tick.
- FSM states and transitions
  - IDLE: tx=1. If !empty, pop into shift register and go to START at the same edge.
  - START: tx=0. On tick, go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. On tick, shift right and increment index; after index 7, go to STOP.
  - STOP: tx=1. On tick:
    - if !empty, pop and go to START (back-to-back frames, no gap);
    - else go to IDLE.
- Frame timing
  - Frame = 10*CLKS_PER_BIT cycles.
  - A push landing in an empty FIFO while IDLE makes tx fall one cycle after the push edge.
- tx is registered (no combinational glitches).
- Reset values (asserted at any time, including mid-frame):
  - state=IDLE, tx=1, FIFO emptied, ovf=0, counter=0, busy=0.
  - The partial frame is abandoned and is not resumed.
- Simultaneous push and pop on a non-full FIFO: both take effect; count unchanged.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; tx = even parity (XOR of the 8 data bits).
  - Frame = 11*CLKS_PER_BIT cycles.
  - STATUS[4] reads 1.
- When undefined: 8N1 framing only; STATUS[4]=0.

Test Plan:
1. CLKS_PER_BIT=4, reset, store 0x000000A5 to BASE:
   - tx low 4 cycles starting one cycle after the store edge;
   - then 1,0,1,0,0,1,0,1 for 4 cycles each;
   - then high 4 cycles;
   - busy falls after 40 cycles.
2. Store 0x41,0x42,0x43 on consecutive cycles:
   - three frames with no idle gap (120 cycles total at CLKS_PER_BIT=4);
   - STATUS count reads 2 right after the first pop.
3. DEPTH=8: while the first frame is sending, store 10 bytes:
   - first byte popped, next 8 queued, 10th dropped;
   - STATUS reads full=1, ovf=1;
   - storing 0x8 to BASE+4 clears ovf;
   - exactly 9 frames are transmitted.
4. Assert reset at cycle 15 of a frame:
   - tx=1 immediately; STATUS reads empty=1, count=0, fsm_active=0;
   - no further tx activity.
5. Store to BASE+8 and BASE-4:
   - hit=0, readdata=0, FIFO unchanged, tx stays 1.
6. With UART_TX_PARITY_EN, send 0x07:
   - parity bit 1 after the data bits;
   - frame lasts 44 cycles at CLKS_PER_BIT=4;
   - STATUS[4]=1.
